// File: rtl/micro_seq_pkg.sv
// rtl/micro_seq_pkg.sv - opcode encodings for the microprogram sequencer
package micro_seq_pkg;

  typedef logic [2:0] op_t;

  localparam op_t NEXT  = 3'd0;
  localparam op_t JUMP  = 3'd1;
  localparam op_t CJMP  = 3'd2;
  localparam op_t CALL  = 3'd3;
  localparam op_t CCALL = 3'd4;
  localparam op_t RET   = 3'd5;
  localparam op_t LDCT  = 3'd6;
  localparam op_t LOOP  = 3'd7;

endpackage

// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - microinstruction fields in, next control-store address out
interface micro_sequencer_if
  import micro_seq_pkg::*;
#(
  parameter int AW = 12
);
  op_t           op;
  logic          cond;
  logic [AW-1:0] din;
  logic [AW-1:0] offset;
  logic [AW-1:0] yout;

  modport master (output op, output cond, output din, output offset, input yout);
  modport slave  (input op, input cond, input din, input offset, output yout);
endinterface

// File: rtl/micro_seq_stack.sv
// rtl/micro_seq_stack.sv - return-address LIFO with level tracking and full/empty status
module micro_seq_stack #(
  parameter int AW    = 12,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty,
  output logic          ovf_evt,
  output logic          unf_evt
);
  localparam int AI = $clog2(DEPTH);
  localparam int LW = AI + 1;

  logic [LW-1:0] level_q, level_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic [AI-1:0] top_idx;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign ovf_evt = push & full;
  assign unf_evt = pop & empty;

  // Low bits of level wrap to 0 when full, so level-1 in AI bits still names the top slot.
  assign top_idx = level_q[AI-1:0] - AI'(1);
  assign top     = mem_q[top_idx];

  always_comb begin
    level_d = level_q;
    if (push && !full) begin
      level_d = level_q + LW'(1);
    end else if (pop && !empty) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem_q[level_q[AI-1:0]] <= wdata;
    end
  end
endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - 2910-class next-address sequencer with stack, loop counter and sticky errors
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 4,
  parameter int CW    = AW
) (
  input  logic               clock,
  input  logic               reset,
  micro_sequencer_if.slave   bus,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               ovf,
  output logic               unf,
  output logic               cnt_zero
);
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [AW-1:0] sel, yout_c, stk_top;
  logic          push, pop, ovf_evt, unf_evt;

  micro_seq_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wdata   (pc_q),
    .top     (stk_top),
    .full    (stack_full),
    .empty   (stack_empty),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  always_comb begin
    sel   = pc_q;
    push  = 1'b0;
    pop   = 1'b0;
    cnt_d = cnt_q;
    case (bus.op)
      JUMP:  sel = bus.din;
      CJMP:  if (bus.cond) sel = bus.din;
      CALL: begin
        sel  = bus.din;
        push = 1'b1;
      end
      CCALL: if (bus.cond) begin
        sel  = bus.din;
        push = 1'b1;
      end
      // An empty-stack return falls through to pc instead of using a stale entry.
      RET: begin
        pop = 1'b1;
        if (!stack_empty) sel = stk_top;
      end
      LDCT:  cnt_d = bus.din[CW-1:0];
      LOOP:  if (cnt_q != '0) begin
        sel   = bus.din;
        cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
    yout_c = sel + bus.offset;
    pc_d   = yout_c + AW'(1);
    ovf_d  = ovf_q | ovf_evt;
    unf_d  = unf_q | unf_evt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.yout = yout_c;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign cnt_zero = (cnt_q == '0);
endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed bench with a queue-based reference model of the sequencer
module tb_micro_sequencer;
  import micro_seq_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << AW) - 1;

  logic clock;
  logic reset;
  logic stack_full, stack_empty, ovf, unf, cnt_zero;

  micro_sequencer_if #(.AW(AW)) bus ();

  micro_sequencer #(.AW(AW), .DEPTH(DEPTH), .CW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .ovf         (ovf),
    .unf         (unf),
    .cnt_zero    (cnt_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  int m_pc, m_cnt;
  bit m_ovf, m_unf;
  int stk[$];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    stk.delete();
  endfunction

  function automatic int model_sel();
    int d = int'(bus.din);
    case (bus.op)
      JUMP:  return d;
      CJMP:  return bus.cond ? d : m_pc;
      CALL:  return d;
      CCALL: return bus.cond ? d : m_pc;
      RET:   return (stk.size() > 0) ? stk[$] : m_pc;
      LOOP:  return (m_cnt != 0) ? d : m_pc;
      default: return m_pc;
    endcase
  endfunction

  function automatic int model_y();
    return (model_sel() + int'(bus.offset)) & MASK;
  endfunction

  function automatic void model_push();
    if (stk.size() == DEPTH) m_ovf = 1'b1;
    else stk.push_back(m_pc);
  endfunction

  function automatic void model_commit();
    int y = model_y();
    case (bus.op)
      CALL:  model_push();
      CCALL: if (bus.cond) model_push();
      RET:   if (stk.size() == 0) m_unf = 1'b1; else void'(stk.pop_back());
      LDCT:  m_cnt = int'(bus.din) & MASK;
      LOOP:  if (m_cnt != 0) m_cnt = m_cnt - 1;
      default: ;
    endcase
    m_pc = (y + 1) & MASK;
  endfunction

  always @(negedge clock) begin
    if (check_en) begin
      check("yout", int'(bus.yout), model_y());
      check("stack_full", int'(stack_full), int'(stk.size() == DEPTH));
      check("stack_empty", int'(stack_empty), int'(stk.size() == 0));
      check("ovf", int'(ovf), int'(m_ovf));
      check("unf", int'(unf), int'(m_unf));
      check("cnt_zero", int'(cnt_zero), int'(m_cnt == 0));
    end
  end

  // Called at posedge+1; drives one microinstruction, pins yout when exp_y >= 0, then commits the model.
  task automatic step(input op_t op, input logic c, input int d, input int off,
                      input int exp_y, input string nm);
    bus.op = op;
    bus.cond = c;
    bus.din = d[AW-1:0];
    bus.offset = off[AW-1:0];
    #1;
    if (exp_y >= 0) check(nm, int'(bus.yout), exp_y);
    @(posedge clock);
    model_commit();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    reset = 1'b1;
    bus.op = NEXT;
    bus.cond = 1'b0;
    bus.din = '0;
    bus.offset = '0;
    model_reset();
    #1;
    check("rst_yout", int'(bus.yout), 0);
    check("rst_empty", int'(stack_empty), 1);
    check("rst_cnt_zero", int'(cnt_zero), 1);
    check("rst_flags", int'({ovf, unf}), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_en = 1'b1;

    for (int i = 0; i < 5; i++) step(NEXT, 1'b0, 0, 0, i, "t1_next");
    check("t1_empty", int'(stack_empty), 1);

    step(CALL, 1'b0, 'h100, 0, 'h100, "t2_call");
    step(NEXT, 1'b0, 0, 0, 'h101, "t2_next1");
    step(NEXT, 1'b0, 0, 0, 'h102, "t2_next2");
    step(RET,  1'b0, 0, 0, 'h005, "t2_ret");
    check("t2_empty", int'(stack_empty), 1);

    step(CALL, 1'b0, 'h200, 0, 'h200, "t3_call1");
    for (int i = 0; i < 3; i++) step(CALL, 1'b0, 'h200, 0, 'h200, "t3_call");
    check("t3_full", int'(stack_full), 1);
    check("t3_no_ovf", int'(ovf), 0);
    step(CALL, 1'b0, 'h200, 0, 'h200, "t3_call5");
    check("t3_ovf", int'(ovf), 1);
    check("t3_still_full", int'(stack_full), 1);
    for (int i = 0; i < 3; i++) step(RET, 1'b0, 0, 0, 'h201, "t3_ret");
    step(RET, 1'b0, 0, 0, 'h006, "t3_ret4");
    check("t3_empty", int'(stack_empty), 1);
    step(RET, 1'b0, 0, 0, 'h007, "t3_ret5");
    check("t3_unf", int'(unf), 1);

    step(LDCT, 1'b0, 3, 0, 'h008, "t4_ldct");
    for (int i = 0; i < 3; i++) step(LOOP, 1'b0, 'h050, 0, 'h050, "t4_loop");
    check("t4_cnt_zero", int'(cnt_zero), 1);
    step(LOOP, 1'b0, 'h050, 0, 'h051, "t4_fall");

    step(CJMP,  1'b0, 'h300, 0, 'h052, "t5_cjmp0");
    step(CCALL, 1'b0, 'h310, 0, 'h053, "t5_ccall0");
    check("t5_nopush", int'(stack_empty), 1);
    step(CJMP,  1'b1, 'h300, 0, 'h300, "t5_cjmp1");
    step(CCALL, 1'b1, 'h310, 0, 'h310, "t5_ccall1");
    check("t5_push", int'(stack_empty), 0);
    step(JUMP,  1'b0, 'h000, 0, 'h000, "t5_jump0");
    step(NEXT,  1'b0, 0, 'hFFF, 'h000, "t5_wrap");
    step(JUMP,  1'b0, 'h123, 'h010, 'h133, "t5_jump_off");

    step(CALL, 1'b0, 'h400, 0, 'h400, "t6_call");
    step(LDCT, 1'b0, 5, 0, 'h401, "t6_ldct");
    step(LOOP, 1'b0, 'h060, 0, 'h060, "t6_loop");
    bus.op = LOOP;
    bus.din = 12'h060;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_yout", int'(bus.yout), 0);
    check("t6_empty", int'(stack_empty), 1);
    check("t6_cnt_zero", int'(cnt_zero), 1);
    check("t6_flags", int'({ovf, unf}), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(NEXT, 1'b0, 0, 0, 0, "t6_after0");
    step(NEXT, 1'b0, 0, 0, 1, "t6_after1");

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
